// File: rtl/mpc_sequencer.sv
// ---------------------------------------------------------------------------
// mpc_sequencer
//
// Microprogram counter sequencer for a microcoded datapath. Each cycle in RUN
// the microinstruction addressed by mpc executes; when it retires, mpc loads
// the next address built from the NEXT_ADDRESS field plus the JAMN/JAMZ/JMPC
// modifiers. Memory wait states hold the current microinstruction (STALL) and
// a halt request freezes the machine until reset (HALT).
//
// Ports
//   clk           in   system clock, all state changes on the rising edge
//   reset         in   synchronous active-high reset
//   next_addr     in   [8:0] NEXT_ADDRESS field of the current microinstruction
//   jamn          in   OR alu_n into bit 8 of the next address
//   jamz          in   OR alu_z into bit 8 of the next address
//   jmpc          in   OR mbr into bits 7:0 of the next address
//   mbr           in   [7:0] opcode byte used for jmpc dispatch
//   alu_n         in   ALU negative result of the current microinstruction
//   alu_z         in   ALU zero result of the current microinstruction
//   mem_busy      in   memory not ready, hold the current microinstruction
//   halt_req      in   request to stop microprogram execution
//   mpc           out  [8:0] current microprogram address
//   n_flag        out  latched N of the last retired microinstruction
//   z_flag        out  latched Z of the last retired microinstruction
//   uinstr_valid  out  mpc addresses an executing microinstruction this cycle
//   stalled       out  sequencer is waiting on memory
//   halted        out  sequencer is halted
//   ucycle_cnt    out  [15:0] retired microinstruction count, wraps silently
// ---------------------------------------------------------------------------
module mpc_sequencer #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              jamn,
    input  logic              jamz,
    input  logic              jmpc,
    input  logic [7:0]        mbr,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              mem_busy,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] mpc,
    output logic              n_flag,
    output logic              z_flag,
    output logic              uinstr_valid,
    output logic              stalled,
    output logic              halted,
    output logic [CNT_W-1:0]  ucycle_cnt
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mpc_q, mpc_d;
    logic                n_q, n_d;
    logic                z_q, z_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                retire;
    logic [ADDR_W-1:0]   target_addr;

    // Next-address formation. The jams look at the ALU outputs of the
    // microinstruction that is executing right now, not at the latched
    // flags, so a conditional branch takes effect on the very next address.
    function automatic logic [ADDR_W-1:0] form_next_addr(
        input logic [ADDR_W-1:0] field,
        input logic              jn,
        input logic              jz,
        input logic              jm,
        input logic [7:0]        opcode,
        input logic              n,
        input logic              z
    );
        logic [ADDR_W-1:0] addr;
        addr          = field;
        addr[8]       = field[8] | (jz & z) | (jn & n);
        addr[7:0]     = field[7:0] | (jm ? opcode : 8'h00);
        return addr;
    endfunction

    assign target_addr = form_next_addr(next_addr, jamn, jamz, jmpc, mbr,
                                        alu_n, alu_z);

    // Stall has priority over halt: a halt request seen together with
    // mem_busy is dropped and only re-sampled once back in RUN.
    assign retire = (state_q == ST_RUN) && !mem_busy && !halt_req;

    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        n_d     = n_q;
        z_d     = z_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_STALL;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STALL: begin
                // Returning to RUN re-executes the same mpc.
                if (!mem_busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (retire) begin
            mpc_d = target_addr;
            n_d   = alu_n;
            z_d   = alu_z;
            cnt_d = cnt_q + 1'b1;   // natural wrap, no overflow flag
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            mpc_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            n_q     <= n_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from registers or from the state decode only,
    // so no input reaches an output combinationally.
    assign mpc          = mpc_q;
    assign n_flag       = n_q;
    assign z_flag       = z_q;
    assign ucycle_cnt   = cnt_q;
    assign uinstr_valid = (state_q == ST_RUN);
    assign stalled      = (state_q == ST_STALL);
    assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_mpc_sequencer.sv
module tb_mpc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  next_addr;
    logic        jamn, jamz, jmpc;
    logic [7:0]  mbr;
    logic        alu_n, alu_z;
    logic        mem_busy, halt_req;
    logic [8:0]  mpc;
    logic        n_flag, z_flag;
    logic        uinstr_valid, stalled, halted;
    logic [15:0] ucycle_cnt;

    always #5 clk = ~clk;

    mpc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .next_addr    (next_addr),
        .jamn         (jamn),
        .jamz         (jamz),
        .jmpc         (jmpc),
        .mbr          (mbr),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .mpc          (mpc),
        .n_flag       (n_flag),
        .z_flag       (z_flag),
        .uinstr_valid (uinstr_valid),
        .stalled      (stalled),
        .halted       (halted),
        .ucycle_cnt   (ucycle_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: machine phase plus architectural registers.
    localparam int M_INIT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;
    int          m_phase;
    int unsigned m_mpc;
    bit          m_n, m_z;
    int unsigned m_cnt;

    task automatic model_edge();
        int unsigned nxt;
        if (reset) begin
            m_phase = M_INIT; m_mpc = 0; m_n = 0; m_z = 0; m_cnt = 0;
        end else begin
            case (m_phase)
                M_INIT:  m_phase = M_RUN;
                M_RUN: begin
                    if (mem_busy)      m_phase = M_STALL;
                    else if (halt_req) m_phase = M_HALT;
                    else begin
                        nxt = next_addr;
                        if ((jamz && alu_z) || (jamn && alu_n)) nxt = nxt | 256;
                        if (jmpc) nxt = nxt | mbr;
                        m_mpc = nxt;
                        m_n   = alu_n;
                        m_z   = alu_z;
                        m_cnt = (m_cnt + 1) % 65536;
                    end
                end
                M_STALL: if (!mem_busy) m_phase = M_RUN;
                default: m_phase = M_HALT;
            endcase
        end
    endtask

    task automatic compare_all(input string pfx);
        chk({pfx, ".mpc"},     32'(mpc),          32'(m_mpc));
        chk({pfx, ".n"},       32'(n_flag),       32'(m_n));
        chk({pfx, ".z"},       32'(z_flag),       32'(m_z));
        chk({pfx, ".cnt"},     32'(ucycle_cnt),   32'(m_cnt));
        chk({pfx, ".valid"},   32'(uinstr_valid), 32'(m_phase == M_RUN));
        chk({pfx, ".stalled"}, 32'(stalled),      32'(m_phase == M_STALL));
        chk({pfx, ".halted"},  32'(halted),       32'(m_phase == M_HALT));
    endtask

    task automatic tick(input bit do_chk, input string pfx);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) compare_all(pfx);
    endtask

    task automatic clear_inputs();
        next_addr = 9'h000; jamn = 0; jamz = 0; jmpc = 0; mbr = 8'h00;
        alu_n = 0; alu_z = 0; mem_busy = 0; halt_req = 0;
    endtask

    int unsigned cnt_before;

    initial begin
        clear_inputs();
        reset = 1'b1;
        m_phase = M_INIT; m_mpc = 0; m_n = 0; m_z = 0; m_cnt = 0;

        // Reset held: outputs at reset values, INIT not yet left
        tick(1, "rst0");
        tick(1, "rst1");
        chk("rst_mpc", 32'(mpc), 32'h0);
        chk("rst_valid", 32'(uinstr_valid), 32'h0);

        // Release: one INIT cycle, then RUN, then first retire
        reset = 1'b0;
        next_addr = 9'h005;
        tick(1, "init");
        chk("run_valid", 32'(uinstr_valid), 32'h1);
        chk("run_mpc0", 32'(mpc), 32'h0);
        tick(1, "ret1");
        chk("ret1_mpc", 32'(mpc), 32'h005);
        chk("ret1_cnt", 32'(ucycle_cnt), 32'h1);

        // JAMZ with same-cycle alu_z
        next_addr = 9'h092; jamz = 1; alu_z = 1;
        tick(1, "jamz1");
        chk("jamz1_mpc", 32'(mpc), 32'h192);
        chk("jamz1_z", 32'(z_flag), 32'h1);
        alu_z = 0;
        tick(1, "jamz0");
        chk("jamz0_mpc", 32'(mpc), 32'h092);
        chk("jamz0_z", 32'(z_flag), 32'h0);
        jamz = 0;

        // JMPC dispatch, then JAMN
        next_addr = 9'h100; jmpc = 1; mbr = 8'h36;
        tick(1, "jmpc");
        chk("jmpc_mpc", 32'(mpc), 32'h136);
        jmpc = 0; jamn = 1; alu_n = 1; next_addr = 9'h000;
        tick(1, "jamn");
        chk("jamn_mpc", 32'(mpc), 32'h100);
        chk("jamn_n", 32'(n_flag), 32'h1);
        clear_inputs();

        // Three-cycle memory stall at 0x010
        next_addr = 9'h010;
        tick(1, "pre_stall");
        chk("pre_stall_mpc", 32'(mpc), 32'h010);
        cnt_before = ucycle_cnt;
        next_addr = 9'h011;
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1, "stall");
            chk("stall_flag", 32'(stalled), 32'h1);
            chk("stall_mpc", 32'(mpc), 32'h010);
            chk("stall_cnt", 32'(ucycle_cnt), 32'(cnt_before));
        end
        mem_busy = 0;
        tick(1, "unstall");
        chk("unstall_valid", 32'(uinstr_valid), 32'h1);
        chk("unstall_mpc", 32'(mpc), 32'h010);
        tick(1, "reexec");
        chk("reexec_mpc", 32'(mpc), 32'h011);
        chk("reexec_cnt", 32'(ucycle_cnt), 32'(cnt_before + 1));

        // Halt during busy: stall wins, halt taken once back in RUN
        halt_req = 1; mem_busy = 1; next_addr = 9'h0AA;
        tick(1, "hb_stall");
        chk("hb_stalled", 32'(stalled), 32'h1);
        mem_busy = 0;
        tick(1, "hb_run");
        chk("hb_valid", 32'(uinstr_valid), 32'h1);
        tick(1, "halt");
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_mpc", 32'(mpc), 32'h011);
        halt_req = 0;
        for (int i = 0; i < 3; i++) tick(1, "halt_hold");
        chk("halt_hold_mpc", 32'(mpc), 32'h011);
        reset = 1;
        tick(1, "halt_rst");
        chk("halt_rst_mpc", 32'(mpc), 32'h0);
        chk("halt_rst_halted", 32'(halted), 32'h0);
        reset = 0;
        clear_inputs();

        // Counter wrap: 65535 retires reach FFFF, next wraps to 0
        tick(1, "wrap_init");
        for (int i = 0; i < 65535; i++) tick(0, "wrap");
        compare_all("wrap_ffff");
        chk("wrap_ffff_cnt", 32'(ucycle_cnt), 32'hFFFF);
        tick(1, "wrap_0");
        chk("wrap_0_cnt", 32'(ucycle_cnt), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            next_addr = 9'($urandom);
            jamn      = 1'($urandom);
            jamz      = 1'($urandom);
            jmpc      = ($urandom_range(0, 3) == 0);
            mbr       = 8'($urandom);
            alu_n     = 1'($urandom);
            alu_z     = 1'($urandom);
            mem_busy  = ($urandom_range(0, 3) == 0);
            halt_req  = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            tick(1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpc_sequencer.md
MPC_SEQUENCER -- requirements
Module: mpc_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled only on rising edge of clk.
REQ-003 next_addr  in  9  NEXT_ADDRESS field of current microinstruction.
REQ-004 jamn  in  1  OR (alu_n) into MPC bit 8 of next address.
REQ-005 jamz  in  1  OR (alu_z) into MPC bit 8 of next address.
REQ-006 jmpc  in  1  OR mbr into MPC bits 7:0 of next address.
REQ-007 mbr  in  8  memory byte register, opcode source for jmpc dispatch.
REQ-008 alu_n  in  1  ALU negative result, same cycle as current microinstruction.
REQ-009 alu_z  in  1  ALU zero result, same cycle as current microinstruction.
REQ-010 mem_busy  in  1  memory not ready; sequencer stalls while high.
REQ-011 halt_req  in  1  request to stop microprogram execution.
REQ-012 mpc  out  9  current microprogram address.
REQ-013 n_flag, z_flag  out  1 each  latched N/Z of last executed microinstruction.
REQ-014 uinstr_valid  out  1  high when mpc addresses an executing microinstruction this cycle.
REQ-015 stalled  out  1  high in STALL state.
REQ-016 halted  out  1  high in HALT state.
REQ-017 ucycle_cnt  out  16  count of executed (retired) microinstructions.

Function
REQ-018 States SHALL be INIT, RUN, STALL, HALT; encoding free.
REQ-019 INIT: lasts exactly one cycle after reset deasserts; mpc=0, uinstr_valid=0; then RUN.
REQ-020 Next address SHALL be: bit8 = next_addr[8] | (jamz & alu_z) | (jamn & alu_n); bits7:0 = next_addr[7:0] | (jmpc ? mbr : 8'h00).
REQ-021 Jam inputs SHALL use same-cycle alu_n/alu_z, not latched flags; zero-cycle decision latency.
REQ-022 RUN, mem_busy=0, halt_req=0: microinstruction retires; at edge mpc<=next address, n_flag<=alu_n, z_flag<=alu_z, ucycle_cnt+=1; stay RUN.
REQ-023 RUN, mem_busy=1: no retire; mpc, flags, counter hold; go STALL.
REQ-024 STALL: uinstr_valid=0, stalled=1; mpc/flags/counter hold; mem_busy=0 -> RUN (same mpc re-executes); else remain.
REQ-025 RUN, mem_busy=0, halt_req=1: no retire; mpc holds; go HALT. halt_req ignored in INIT and STALL.
REQ-026 mem_busy=1 and halt_req=1 in RUN: stall wins; halt_req re-sampled once back in RUN.
REQ-027 HALT: halted=1, uinstr_valid=0, all registers hold; exit only by reset.
REQ-028 uinstr_valid SHALL be 1 exactly in RUN.
REQ-029 ucycle_cnt SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-030 All outputs SHALL be registered or decoded solely from state; no input-to-output combinational path.

Reset
REQ-031 reset=1 at an edge SHALL force INIT, mpc=9'h000, n_flag=0, z_flag=0, ucycle_cnt=0, stalled=0, halted=0, uinstr_valid=0, regardless of current state (incl. mid-STALL, HALT).
REQ-032 reset held high: outputs remain at reset values; INIT's single cycle starts at first edge with reset=0.

Verification
REQ-033 Reset release, next_addr=9'h005, no jams -> cycle1 mpc=0 valid=0; cycle2 valid=1; next edge mpc=9'h005, ucycle_cnt=1.
REQ-034 RUN, next_addr=9'h092, jamz=1, alu_z=1 -> mpc=9'h192, z_flag=1; repeat alu_z=0 -> mpc=9'h092, z_flag=0.
REQ-035 RUN, next_addr=9'h100, jmpc=1, mbr=8'h36 -> mpc=9'h136; with jamn=1, alu_n=1, next_addr=9'h000 -> mpc=9'h100.
REQ-036 mem_busy high 3 cycles at mpc=9'h010 -> stalled=1 for 3 cycles, mpc/ucycle_cnt unchanged, then RUN re-executes 9'h010.
REQ-037 halt_req with mem_busy=1 -> STALL first; halt_req still high after busy clears -> HALT, mpc frozen; reset -> INIT, mpc=0.
REQ-038 Preload ucycle_cnt to 16'hFFFF via 65535 retires -> next retire yields 16'h0000.
